// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch FSM encoding, reset PC and the bubble
// instruction that IF/ID loads on flush.
package rv32i_types;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        KILL
    } fetch_state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;

endpackage

// File: rtl/fetch_hold_buf.sv
// 32-bit holding register with synchronous clear (priority) and load.
// Used for the stalled instruction and for the pending redirect target.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] buf_q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            buf_q <= 32'h0;
        end else if (load) begin
            buf_q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs the I-memory read handshake and feeds IF/ID,
// absorbing ID stalls and EX redirects without losing or duplicating fetches.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC  = rv32i_types::RESET_PC,
    parameter logic [31:0] NOP_INSTR = rv32i_types::NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  hold_instr_q, pend_target_q;
    logic         hold_load, hold_clear;
    logic         pend_load;
    logic [31:0]  instr_src;

    assign pc_plus4      = pc_q + 32'd4;
    assign ifid_pc       = pc_q;
    assign ifid_pc_plus4 = pc_plus4;
    assign imem_address  = pc_q;
    assign instr_src     = (state_q == HOLD) ? hold_instr_q : imem_rdata;
    assign ifid_instr    = ifid_flush ? NOP_INSTR : instr_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_hold_buf u_hold_instr (
        .clk   (clk),
        .clear (hold_clear),
        .load  (hold_load),
        .d     (imem_rdata),
        .buf_q (hold_instr_q)
    );

    fetch_hold_buf u_pend_target (
        .clk   (clk),
        .clear (rst),
        .load  (pend_load),
        .d     (redirect_target),
        .buf_q (pend_target_q)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imem_read  = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        hold_load  = 1'b0;
        hold_clear = rst;
        pend_load  = 1'b0;

        if (!rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        if (redirect) begin
                            pc_d       = redirect_target;
                            ifid_en    = 1'b1;
                            ifid_flush = 1'b1;
                        end else if (stall) begin
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            ifid_en = 1'b1;
                            pc_d    = pc_plus4;
                        end
                    end else if (redirect) begin
                        // The request at pc is already out; remember where to go once it lands.
                        pend_load  = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        state_d    = KILL;
                    end else if (!stall) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        hold_clear = 1'b1;
                        pc_d       = redirect_target;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        state_d    = FETCH;
                    end else if (!stall) begin
                        ifid_en = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
                end
                KILL: begin
                    imem_read  = 1'b1;
                    ifid_en    = !stall || redirect;
                    ifid_flush = ifid_en;
                    pend_load  = redirect;
                    if (imem_resp) begin
                        pc_d    = redirect ? redirect_target : pend_target_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule
